// File: rtl/uart_dbg_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_dbg_tx_pkg
// Brief   : Shared state encoding, line levels and helpers for uart_dbg_tx.
// Revision: 1.0 - initial release
// ============================================================================
package uart_dbg_tx_pkg;

    // Transmit FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Serial line levels
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Index of the final data bit (LSB first, 8 bits)
    localparam logic [2:0] LAST_BIT = 3'd7;

    // Even parity: the parity bit makes the total count of ones even
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_dbg_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock FIFO with a registered occupancy level. Read data is
//           presented combinationally from the head entry.
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty derive from the level register only, so a same-cycle pop
    // never opens a slot for a push while full.
    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage write; contents need no reset because level gates all reads
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and level bookkeeping; push+pop leaves level unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                level <= level - (AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_dbg_tx.sv
`default_nettype none
// ============================================================================
// Module  : uart_dbg_tx
// Brief   : Byte-stream UART transmitter (8N1, optional even parity) feeding
//           the SoC debug input line. Bytes enter a small FIFO over a
//           valid/ready handshake and are serialised at a fixed baud divisor.
// Revision: 1.0 - initial release
// ============================================================================
module uart_dbg_tx
    import uart_dbg_tx_pkg::*;
#(
    parameter int BAUD_DIV  = 434,
    parameter int FIFO_AW   = 2,
    parameter int PARITY_EN = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               tx_pin,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int              CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tx_state_e        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shifter;
    logic             par_bit;

    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rdata;
    logic             pop;
    logic             bit_end;
    logic             line_next;

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign bit_end  = (baud_cnt == CNT_LAST);
    assign tx_ready = !fifo_full;
    assign busy     = (state != ST_IDLE) || (fifo_level != '0);

    // Pop when idle, or on the last stop-bit cycle so frames abut with no gap
    assign pop = !fifo_empty &&
                 ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

    // Line level implied by the current state; registered into tx_pin
    always_comb begin
        line_next = LINE_IDLE;
        case (state)
            ST_START:  line_next = LINE_START;
            ST_DATA:   line_next = shifter[0];
            ST_PARITY: line_next = par_bit;
            default:   line_next = LINE_IDLE;
        endcase
    end

    // Frame sequencer: baud counter, bit index, shifter and registered line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shifter  <= '0;
            par_bit  <= 1'b0;
            tx_pin   <= LINE_IDLE;
        end else begin
            tx_pin <= line_next;
            if (pop) begin
                shifter <= fifo_rdata;
                par_bit <= even_parity(fifo_rdata);
            end
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shifter  <= {1'b0, shifter[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
                            state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= pop ? ST_START : ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
